// File: rtl/jc_pkg.sv
// Shared types and helpers for the Johnson-code decoder. The block's build option
// (JC_DIR_DETECT_EN) is used in jc_decoder.sv.
package jc_pkg;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} jc_state_e;

  // Width of a position index for a W-bit code (2W positions)
  function automatic int unsigned jc_idx_w(input int unsigned w);
    return $clog2(2 * w);
  endfunction

  function automatic int unsigned jc_popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // Ones growing from bit 0 are the first half of the cycle, ones anchored at
  // the top the second half.
  function automatic int unsigned jc_decode_idx(input int unsigned pop, input logic lsb,
                                                input int unsigned w);
    return (lsb || pop == 0) ? pop : 2 * w - pop;
  endfunction

endpackage

// File: rtl/jc_code_decode.sv
// Combinational Johnson-code check and decode: sample -> {legal, position}.
module jc_code_decode import jc_pkg::*; #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]                  i_q,
  output logic                              legal,
  output logic [jc_idx_w(WIDTH)-1:0]        idx
);
  localparam int IW = jc_idx_w(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nq;
  assign nq = ~i_q;

  // x is a low-aligned mask (2^k-1) iff x & (x+1) == 0; test q and ~q
  assign legal = ((i_q & (i_q + ONE)) == '0) || ((nq & (nq + ONE)) == '0);
  assign idx   = IW'(jc_decode_idx(jc_popcount(32'(i_q)), i_q[0], WIDTH));

endmodule

// File: rtl/jc_decoder.sv
// Johnson-code receiver: tracks the sampled code stream, reports lock/wrap/errors.
// Build option JC_DIR_DETECT_EN: accept reverse steps and report direction on o_dir.
module jc_decoder import jc_pkg::*; #(
  parameter int WIDTH     = 3,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [WIDTH-1:0]            i_q,
  input  logic                        i_en,
  output logic [jc_idx_w(WIDTH)-1:0]  o_idx,
  output logic                        o_valid,
  output logic                        o_locked,
  output logic                        o_err,
  output logic [ERR_CNT_W-1:0]        o_err_cnt,
  output logic                        o_wrap,
  output logic                        o_dir
);
  localparam int IW = jc_idx_w(WIDTH);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [IW-1:0] LAST = IW'(2 * WIDTH - 1);
  localparam logic [RW-1:0] LOCK = RW'(LOCK_CNT);

  jc_state_e state;
  logic [IW-1:0] prev, idx, fwd_idx, rev_idx;
  logic [RW-1:0] run, run_inc;
  logic [ERR_CNT_W-1:0] cnt_inc;
  logic legal;

  jc_code_decode #(.WIDTH(WIDTH)) u_dec (.i_q(i_q), .legal(legal), .idx(idx));

  // Neighbours of the previous position on the 2W-long ring
  assign fwd_idx = (prev == LAST) ? '0 : prev + IW'(1);
  assign rev_idx = (prev == '0) ? LAST : prev - IW'(1);
  assign run_inc = (run == LOCK) ? run : run + RW'(1);
  assign cnt_inc = (&o_err_cnt) ? o_err_cnt : o_err_cnt + ERR_CNT_W'(1);
  assign o_locked = (state == LOCKED);

`ifndef JC_DIR_DETECT_EN
  assign o_dir = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= SEARCH;
      prev      <= '0;
      run       <= '0;
      o_idx     <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
      o_wrap    <= 1'b0;
`ifdef JC_DIR_DETECT_EN
      o_dir     <= 1'b0;
`endif
    end else begin
      o_err  <= 1'b0;
      o_wrap <= 1'b0;
      if (i_en) begin
        if (!legal) begin
          o_err     <= 1'b1;
          o_err_cnt <= cnt_inc;
          o_valid   <= 1'b0;
          run       <= '0;
          state     <= SEARCH;
        end else begin
          o_valid <= 1'b1;
          o_idx   <= idx;
          if (state == SEARCH) begin
            prev  <= idx;
            run   <= '0;
            state <= TRACK;
          end else if (idx == prev) begin
            // repeated sample: nothing advances
          end else if (idx == fwd_idx) begin
            prev   <= idx;
            run    <= run_inc;
            o_wrap <= (prev == LAST);
            if (run_inc == LOCK) state <= LOCKED;
`ifdef JC_DIR_DETECT_EN
            o_dir  <= 1'b0;
          end else if (idx == rev_idx) begin
            prev   <= idx;
            run    <= run_inc;
            o_wrap <= (prev == '0);
            o_dir  <= 1'b1;
            if (run_inc == LOCK) state <= LOCKED;
`endif
          end else begin
            // skip: resync to the new position and start counting again
            prev      <= idx;
            run       <= '0;
            o_err     <= 1'b1;
            o_err_cnt <= cnt_inc;
            state     <= TRACK;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jc_decoder.sv
// Bench for jc_decoder (W=3, LOCK_CNT=2, ERR_CNT_W=2): behavioural model feeds a scoreboard.
module tb_jc_decoder;
  localparam int W = 3;
  localparam int N = 2 * W;
  localparam int L = 2;
  localparam int EW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [W-1:0] q = '0;
  logic [2:0] idx;
  logic valid, locked, err, wrap, dir;
  logic [EW-1:0] err_cnt;

  jc_decoder #(.WIDTH(W), .LOCK_CNT(L), .ERR_CNT_W(EW)) dut (
    .i_clk(clk), .i_rst(rst), .i_q(q), .i_en(en),
    .o_idx(idx), .o_valid(valid), .o_locked(locked), .o_err(err),
    .o_err_cnt(err_cnt), .o_wrap(wrap), .o_dir(dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx; int valid; int locked; int err; int cnt; int wrap; int dir;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int m_state = 0, m_prev = 0, m_run = 0;
  exp_t m;
  logic [W-1:0] seq [N];

`ifdef JC_DIR_DETECT_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic model(input logic [W-1:0] qq, input logic e, input logic r);
    int k;
    m.err = 0;
    m.wrap = 0;
    if (r) begin
      m = '{0, 0, 0, 0, 0, 0, 0};
      m_state = 0; m_prev = 0; m_run = 0;
    end else if (e) begin
      k = -1;
      for (int i = 0; i < N; i++) if (seq[i] == qq) k = i;
      if (k < 0) begin
        m.err = 1; m.valid = 0; m_state = 0; m_run = 0;
        if (m.cnt < 3) m.cnt++;
      end else begin
        m.valid = 1; m.idx = k;
        if (m_state == 0) begin
          m_prev = k; m_run = 0; m_state = 1;
        end else if (k == m_prev) begin
        end else if (k == (m_prev + 1) % N) begin
          m.wrap = (m_prev == N - 1);
          m.dir = 0;
          m_prev = k;
          if (m_run < L) m_run++;
          if (m_run == L) m_state = 2;
        end else if (DIR_EN && k == (m_prev + N - 1) % N) begin
          m.wrap = (m_prev == 0);
          m.dir = 1;
          m_prev = k;
          if (m_run < L) m_run++;
          if (m_run == L) m_state = 2;
        end else begin
          m.err = 1; m_run = 0; m_state = 1; m_prev = k;
          if (m.cnt < 3) m.cnt++;
        end
      end
    end
    m.locked = (m_state == 2);
  endtask

  // drive one cycle, predict, then compare the registered outputs after the edge
  task automatic cyc(input logic [W-1:0] qq, input logic e, input logic r = 1'b0);
    exp_t x;
    @(negedge clk);
    q = qq; en = e; rst = r;
    model(qq, e, r);
    sb.push_back(m);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("idx", int'(idx), x.idx);
    chk("valid", int'(valid), x.valid);
    chk("locked", int'(locked), x.locked);
    chk("err", int'(err), x.err);
    chk("err_cnt", int'(err_cnt), x.cnt);
    chk("wrap", int'(wrap), x.wrap);
    chk("dir", int'(dir), x.dir);
    chk("err_wrap_excl", int'(err & wrap), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = s;
      s = {s[W-2:0], ~s[W-1]};
    end

    cyc(3'b000, 1'b0, 1'b1);
    chk("reset_idx", int'(idx), 0);
    chk("reset_locked", int'(locked), 0);

    // acquire lock
    cyc(3'b000, 1'b1);
    cyc(3'b001, 1'b1);
    cyc(3'b011, 1'b1);
    chk("lock_after_011", int'(locked), 1);
    chk("idx_after_011", int'(idx), 2);
    // full lap with wrap 5 -> 0
    cyc(3'b111, 1'b1);
    cyc(3'b110, 1'b1);
    cyc(3'b100, 1'b1);
    cyc(3'b000, 1'b1);
    chk("wrap_pulse", int'(wrap), 1);
    cyc(3'b000, 1'b1);
    chk("wrap_one_cycle", int'(wrap), 0);

    // illegal code while locked, then relock
    cyc(3'b001, 1'b1);
    cyc(3'b011, 1'b1);
    cyc(3'b010, 1'b1);
    chk("illegal_cnt", int'(err_cnt), 1);
    cyc(3'b011, 1'b1);
    cyc(3'b111, 1'b1);
    cyc(3'b110, 1'b1);
    chk("relock", int'(locked), 1);

    // skip while locked at 001
    cyc(3'b100, 1'b1);
    cyc(3'b000, 1'b1);
    cyc(3'b001, 1'b1);
    cyc(3'b111, 1'b1);
    chk("skip_idx", int'(idx), 3);
    chk("skip_err", int'(err), 1);

    // relock, then reverse step from 011 to 001
    cyc(3'b110, 1'b1);
    cyc(3'b100, 1'b1);
    cyc(3'b000, 1'b1);
    cyc(3'b001, 1'b1);
    cyc(3'b011, 1'b1);
    cyc(3'b001, 1'b1);
    chk("reverse_err", int'(err), DIR_EN ? 0 : 1);
    // reverse through the wrap point
    cyc(3'b000, 1'b1);
    cyc(3'b100, 1'b1);
    cyc(3'b000, 1'b1);

    // enable gaps with junk on the bus
    for (int i = 0; i < 4; i++) cyc(W'($urandom), 1'b0);

    // saturation of the 2-bit error counter
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b010, 1'b1);
    cyc(3'b101, 1'b1);
    cyc(3'b010, 1'b1);
    cyc(3'b101, 1'b1);
    cyc(3'b010, 1'b1);
    chk("err_cnt_sat", int'(err_cnt), 3);

    // reset while locked clears everything
    cyc(3'b000, 1'b1);
    cyc(3'b001, 1'b1);
    cyc(3'b011, 1'b1);
    cyc(3'b111, 1'b1);
    cyc(3'b110, 1'b1, 1'b1);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_valid", int'(valid), 0);
    cyc(3'b110, 1'b0);
    cyc(3'b011, 1'b0);

    // random mix: mostly legal steps, some holds, skips and illegal codes
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) s = seq[(m_prev + 1) % N];
      else if (r < 7) s = seq[(m_prev + N - 1) % N];
      else s = W'($urandom);
      cyc(s, ($urandom_range(0, 4) != 0), ($urandom_range(0, 60) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
